// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter granting four byte requesters packet-locked access to one uart_tx
module uart_tx_arb #(
    parameter int FRAME_CYCLES = 4800,
    parameter int CNT_W        = 13,
    parameter int MAX_BURST    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_req,
    input  logic [3:0]  i_req_last,
    input  logic [31:0] i_req_dat,
    output logic [3:0]  o_gnt,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_dat,
    output logic        o_busy,
    output logic [1:0]  o_owner
);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [BURST_W-1:0] r_burst;
    logic               r_end;
    logic [3:0]         r_gnt;
    logic               r_tx_en;
    logic [7:0]         r_tx_dat;
    logic [1:0]         w_win;
    logic [1:0]         w_sel;
    logic               w_cnt_zero;
    logic               w_more;
    logic               w_issue;
    logic               w_release;

    // first pending requester at or after the round-robin pointer
    always_comb begin
        w_win = r_ptr;
        for (int j = 3; j >= 0; j--)
            if (i_req[r_ptr + 2'(j)]) w_win = r_ptr + 2'(j);
    end

    // issue/release decisions; in SEND only the owner's request is looked at
    always_comb begin
        w_cnt_zero = r_cnt == '0;
        w_more     = !r_end && i_req[r_owner] && (r_burst < BURST_W'(MAX_BURST));
        w_issue    = (r_state == IDLE) ? |i_req : (w_cnt_zero && w_more);
        w_release  = (r_state == SEND) && w_cnt_zero && !w_more;
        w_sel      = (r_state == IDLE) ? w_win : r_owner;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // next state: lock on any issue, unlock on release
    always_comb begin
        w_state_nxt = w_issue ? SEND : (w_release ? IDLE : r_state);
    end

    // registered datapath: byte load, frame spacing counter, burst count, pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= 2'd0;
            r_owner  <= 2'd0;
            r_cnt    <= '0;
            r_burst  <= '0;
            r_end    <= 1'b0;
            r_gnt    <= 4'b0000;
            r_tx_en  <= 1'b0;
            r_tx_dat <= 8'h00;
        end else begin
            r_tx_en <= w_issue;
            r_gnt   <= w_issue ? (4'b0001 << w_sel) : 4'b0000;
            if (w_issue) begin
                r_owner  <= w_sel;
                r_tx_dat <= i_req_dat[{w_sel, 3'b000} +: 8];
                r_cnt    <= CNT_W'(FRAME_CYCLES - 1);
                r_burst  <= (r_state == IDLE) ? BURST_W'(1) :
                            (r_burst == BURST_W'(MAX_BURST)) ? r_burst : r_burst + BURST_W'(1);
                r_end    <= i_req_last[w_sel];
            end else if (r_state == SEND && !w_cnt_zero) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_release) r_ptr <= r_owner + 2'd1;
        end
    end

    // outputs straight from registers
    always_comb begin
        o_gnt    = r_gnt;
        o_tx_en  = r_tx_en;
        o_tx_dat = r_tx_dat;
        o_busy   = r_state == SEND;
        o_owner  = r_owner;
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: random stimulus against a timestamp-based reference model of the arbiter
module tb_uart_tx_arb;
    localparam int FC = 20;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_dat;
    logic [3:0]  gnt;
    logic        tx_en;
    logic [7:0]  tx_dat;
    logic        busy;
    logic [1:0]  owner;

    int n_chk = 0;
    int n_pass = 0;

    int         m_c, m_last, m_ptr, m_owner, m_bytes;
    bit         m_lock, m_end, m_en;
    logic [7:0] m_dat;
    logic [3:0] m_gnt;

    uart_tx_arb #(.FRAME_CYCLES(FC), .CNT_W(13), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_req_last(req_last), .i_req_dat(req_dat),
        .o_gnt(gnt), .o_tx_en(tx_en), .o_tx_dat(tx_dat), .o_busy(busy), .o_owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_lock = 0; m_end = 0; m_en = 0; m_ptr = 0; m_owner = 0; m_bytes = 0;
        m_dat = 8'h00; m_gnt = 4'b0000; m_last = m_c;
    endtask

    task automatic give(input int w, input bit fresh);
        m_lock  = 1;
        m_owner = w;
        m_dat   = req_dat[8*w +: 8];
        m_en    = 1;
        m_gnt   = 4'b0001 << w;
        m_last  = m_c;
        m_bytes = fresh ? 1 : m_bytes + 1;
        m_end   = req_last[w];
    endtask

    task automatic model_step();
        bit found;
        m_c++;
        m_en  = 0;
        m_gnt = 4'b0000;
        if (!rst_n) begin
            model_reset();
        end else if (!m_lock) begin
            found = 0;
            for (int o = 0; o < 4; o++)
                if (!found && req[(m_ptr + o) % 4]) begin
                    give((m_ptr + o) % 4, 1);
                    found = 1;
                end
        end else if (m_c - m_last == FC) begin
            if (!m_end && req[m_owner] && m_bytes < MB) give(m_owner, 0);
            else begin
                m_lock = 0;
                m_ptr  = (m_owner + 1) % 4;
            end
        end
    endtask

    task automatic check_all();
        chk("tx_en", 32'(tx_en), 32'(m_en));
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("busy", 32'(busy), 32'(m_lock));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("tx_dat", 32'(tx_dat), 32'(m_dat));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        m_c = 0;
        rst_n = 1'b0; req = 4'b0000; req_last = 4'b0000; req_dat = 32'h0;
        model_reset();
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_dat", 32'(tx_dat), 32'h00);
        rst_n = 1'b1;

        req = 4'b0010; req_last = 4'b0010; req_dat = 32'h0000A500;
        cycle();
        chk("single_en", 32'(tx_en), 32'h1);
        chk("single_dat", 32'(tx_dat), 32'hA5);
        chk("single_gnt", 32'(gnt), 32'h2);
        chk("single_owner", 32'(owner), 32'h1);
        req = 4'b0000; req_last = 4'b0000;
        repeat (19) cycle();
        chk("single_busy19", 32'(busy), 32'h1);
        cycle();
        chk("single_busy20", 32'(busy), 32'h0);
        req = 4'b1111; req_last = 4'b1111; req_dat = $urandom;
        cycle();
        chk("ptr_after_single", 32'(owner), 32'h2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req = 4'($urandom);
            req_last = 4'($urandom & $urandom & $urandom);
            req_dat  = $urandom;
            cycle();
        end

        req = 4'b1000; req_last = 4'b0000;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            req_dat = $urandom;
            cycle();
            seen = tx_en;
        end
        chk("rst_wait_en", 32'(seen), 32'h1);
        repeat (9) cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_mid_busy", 32'(busy), 32'h0);
        req = 4'b1010; req_last = 4'b1010;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_owner", 32'(owner), 32'h1);
        chk("post_rst_en", 32'(tx_en), 32'h1);
        repeat (5) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
